// File: rtl/sram_ctrl_burst_if.sv
// sram_ctrl_burst_if: user-side request/response port of the burst SRAM controller
interface sram_ctrl_burst_if #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = 8
);
  localparam int NB    = DATA_W / 8;
  localparam int LEN_W = $clog2(BURST_MAX) + 1;
  logic              mem;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [NB-1:0]     be;
  logic [LEN_W-1:0]  burst_len;
  logic [DATA_W-1:0] data_f2s;
  logic              wr_ack;
  logic              ready;
  logic [DATA_W-1:0] data_s2f_r;
  logic              rd_valid;
  logic [DATA_W-1:0] data_s2f_ur;
  modport master (
    output mem, rw, addr, be, burst_len, data_f2s,
    input  wr_ack, ready, data_s2f_r, rd_valid, data_s2f_ur
  );
  modport slave (
    input  mem, rw, addr, be, burst_len, data_f2s,
    output wr_ack, ready, data_s2f_r, rd_valid, data_s2f_ur
  );
endinterface

// File: rtl/sram_ctrl_burst.sv
// sram_ctrl_burst: async-SRAM controller with byte enables, wait states and incrementing bursts
module sram_ctrl_burst #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int WAIT_CYC  = 1,
  parameter int BURST_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_ctrl_burst_if.slave      u,
  output logic [ADDR_W-1:0]     ad,
  output logic                  we_n,
  output logic                  oe_n,
  output logic                  ce_n,
  output logic [DATA_W/8-1:0]   be_n,
  inout  wire  [DATA_W-1:0]     dio
);
  localparam int NB    = DATA_W / 8;
  localparam int LEN_W = $clog2(BURST_MAX) + 1;
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR_SETUP = 2'd2, WR_PULSE = 2'd3;
  localparam logic [3:0] W_LAST = 4'(WAIT_CYC);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(BURST_MAX);
  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]  left_q, left_d, len_in;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0]     be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              last, more, wr_ack, wr_phase;
  assign last     = cnt_q == W_LAST;
  assign more     = left_q > LEN_W'(1);
  assign wr_phase = state_q == WR_SETUP || state_q == WR_PULSE;
  assign len_in   = u.burst_len == '0 ? LEN_W'(1) : u.burst_len > LEN_MAX ? LEN_MAX : u.burst_len;
  // First word is acked at accept, later words at the end of the previous pulse
  assign wr_ack   = (state_q == IDLE && u.mem && !u.rw) || (state_q == WR_PULSE && last && more);
  assign u.wr_ack      = wr_ack;
  assign u.ready       = state_q == IDLE;
  assign u.data_s2f_r  = rdata_q;
  assign u.rd_valid    = rd_valid_q;
  assign u.data_s2f_ur = dio;
  assign ad   = addr_q;
  assign ce_n = state_q == IDLE;
  assign oe_n = state_q != RD;
  assign we_n = state_q != WR_PULSE;
  assign be_n = state_q == IDLE ? '1 : ~be_q;
  assign dio  = wr_phase ? wdata_q : 'z;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wr_ack ? u.data_f2s : wdata_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: if (u.mem) begin
        addr_d  = u.addr;
        be_d    = u.be;
        left_d  = len_in;
        cnt_d   = '0;
        state_d = u.rw ? RD : WR_SETUP;
      end
      RD: begin
        cnt_d = last ? '0 : cnt_q + 4'd1;
        if (last) begin
          rdata_d    = dio;
          rd_valid_d = 1'b1;
          left_d     = left_q - LEN_W'(1);
          addr_d     = more ? addr_q + 1'b1 : addr_q;
          state_d    = more ? RD : IDLE;
        end
      end
      WR_SETUP: begin
        cnt_d   = '0;
        state_d = WR_PULSE;
      end
      default: begin
        cnt_d = last ? '0 : cnt_q + 4'd1;
        if (last) begin
          left_d  = left_q - LEN_W'(1);
          addr_d  = more ? addr_q + 1'b1 : addr_q;
          state_d = more ? WR_SETUP : IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      left_q     <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end
endmodule

// File: tb/tb_sram_ctrl_burst.sv
// tb_sram_ctrl_burst: directed checks of the burst SRAM controller against a behavioural SRAM
module tb_sram_ctrl_burst;
  logic clk, reset;
  logic [17:0] ad;
  logic we_n, oe_n, ce_n;
  logic [1:0] be_n;
  wire  [15:0] dio;
  int total = 0, bad = 0;
  logic [15:0] sram [0:262143];
  logic [15:0] wbuf [8];
  logic [17:0] adq[$];
  logic [1:0]  beq[$];
  logic [15:0] rq[$];
  int          rcq[$];
  int acks, cyc, busy;

  sram_ctrl_burst_if #(.ADDR_W(18), .DATA_W(16), .BURST_MAX(8)) u ();

  sram_ctrl_burst #(.ADDR_W(18), .DATA_W(16), .WAIT_CYC(1), .BURST_MAX(8)) dut (
    .clk(clk), .reset(reset), .u(u), .ad(ad), .we_n(we_n), .oe_n(oe_n),
    .ce_n(ce_n), .be_n(be_n), .dio(dio)
  );

  assign dio = (!ce_n && !oe_n && we_n) ? sram[ad] : 'z;
  always @(posedge clk) if (!ce_n && !we_n) begin
    if (!be_n[0]) sram[ad][7:0]  <= dio[7:0];
    if (!be_n[1]) sram[ad][15:8] <= dio[15:8];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [17:0] a, input logic [1:0] b, input logic [3:0] len);
    logic prev_we;
    int c;
    acks = 0; prev_we = 1'b1; adq.delete(); beq.delete();
    @(negedge clk);
    u.mem = 1'b1; u.rw = 1'b0; u.addr = a; u.be = b; u.burst_len = len; u.data_f2s = wbuf[0];
    for (c = 0; c < 60; c++) begin
      #1;
      if (u.wr_ack) acks++;
      if (c > 0 && u.ready) break;
      if (!we_n && prev_we) begin adq.push_back(ad); beq.push_back(be_n); end
      prev_we = we_n;
      @(negedge clk);
      u.mem = 1'b0;
      u.data_f2s = acks < 8 ? wbuf[acks] : 16'h0;
    end
    cyc = c;
    check("wr_timeout", 32'(c < 60), 32'd1);
  endtask

  task automatic do_read(input logic [17:0] a, input logic [3:0] len, input bit poke);
    int c;
    rq.delete(); rcq.delete();
    @(negedge clk);
    u.mem = 1'b1; u.rw = 1'b1; u.addr = a; u.be = 2'b11; u.burst_len = len;
    for (c = 0; c < 60; c++) begin
      #1;
      if (u.rd_valid) begin rq.push_back(u.data_s2f_r); rcq.push_back(c); end
      if (c > 0 && u.ready) break;
      @(negedge clk);
      u.mem = poke && c == 1;
      u.rw  = !(poke && c == 1);
    end
    cyc = c;
    check("rd_timeout", 32'(c < 60), 32'd1);
    check("rd_end_oe_n", 32'(oe_n), 32'd1);
    check("rd_end_ce_n", 32'(ce_n), 32'd1);
    check("rd_end_we_n", 32'(we_n), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    u.mem = 1'b0; u.rw = 1'b1; u.addr = '0; u.be = 2'b11; u.burst_len = 4'd1; u.data_f2s = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(u.ready), 32'd1);
    check("rst_strobes", {29'd0, ce_n, oe_n, we_n}, 32'h7);
    check("rst_be_n", 32'(be_n), 32'h3);
    check("rst_ad", 32'(ad), 32'h0);
    check("rst_rdata", 32'(u.data_s2f_r), 32'h0);
    check("rst_flags", {30'd0, u.rd_valid, u.wr_ack}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // reset in the middle of a write pulse
    @(negedge clk);
    u.mem = 1'b1; u.rw = 1'b0; u.addr = 18'h40; u.be = 2'b11; u.burst_len = 4'd4; u.data_f2s = 16'h7777;
    @(negedge clk);
    u.mem = 1'b0;
    @(negedge clk);
    #1;
    check("pulse_we_n", 32'(we_n), 32'd0);
    reset = 1'b1;
    #1;
    check("arst_we_n", 32'(we_n), 32'd1);
    check("arst_ce_n", 32'(ce_n), 32'd1);
    check("arst_ready", 32'(u.ready), 32'd1);
    check("arst_be_n", 32'(be_n), 32'h3);
    @(negedge clk);
    reset = 1'b0;
    busy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (u.wr_ack || u.rd_valid || !ce_n) busy++;
    end
    check("post_rst_quiet", 32'(busy), 32'd0);

    // single write then read back
    wbuf[0] = 16'h00F0;
    do_write(18'hF0, 2'b11, 4'd1);
    check("single_acks", 32'(acks), 32'd1);
    check("single_wr_cyc", 32'(cyc), 32'd4);
    do_read(18'hF0, 4'd1, 1'b0);
    check("single_rd_n", 32'(rq.size()), 32'd1);
    check("single_rd_data", 32'(rq.size() > 0 ? rq[0] : 16'h0), 32'h00F0);
    check("single_rd_cyc", 32'(rcq.size() > 0 ? rcq[0] : -1), 32'd3);

    // byte lanes
    wbuf[0] = 16'hFFFF;
    do_write(18'h10, 2'b11, 4'd1);
    wbuf[0] = 16'hAB12;
    do_write(18'h10, 2'b01, 4'd1);
    check("lane_be_n", 32'(beq.size() > 0 ? beq[0] : 2'b11), 32'h2);
    do_read(18'h10, 4'd1, 1'b0);
    check("lane_rd_data", 32'(rq.size() > 0 ? rq[0] : 16'h0), 32'hFF12);

    // 4-word burst wrapping the address space
    for (int i = 0; i < 4; i++) wbuf[i] = 16'h1111 * 16'(i + 1);
    do_write(18'h3FFFE, 2'b11, 4'd4);
    check("burst_acks", 32'(acks), 32'd4);
    check("burst_wr_cyc", 32'(cyc), 32'd13);
    check("burst_ad_n", 32'(adq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("burst_ad%0d", i), 32'(i < adq.size() ? adq[i] : 18'h0), 32'((18'h3FFFE + 18'(i)) & 18'h3FFFF));
    do_read(18'h3FFFE, 4'd4, 1'b0);
    check("burst_rd_n", 32'(rq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_rd%0d", i), 32'(i < rq.size() ? rq[i] : 16'h0), 32'h1111 * 32'(i + 1));
      check($sformatf("burst_rcyc%0d", i), 32'(i < rcq.size() ? rcq[i] : -1), 32'(2 * i + 3));
    end
    check("burst_rd_cyc", 32'(cyc), 32'd9);

    // length clamp
    wbuf[0] = 16'hC0DE; wbuf[1] = 16'hBAD1;
    do_write(18'h100, 2'b11, 4'd0);
    check("len0_acks", 32'(acks), 32'd1);
    check("len0_words", 32'(adq.size()), 32'd1);
    for (int i = 0; i < 8; i++) wbuf[i] = 16'h5000 + 16'(i);
    do_write(18'h200, 2'b11, 4'd15);
    check("len15_acks", 32'(acks), 32'd8);
    check("len15_words", 32'(adq.size()), 32'd8);
    check("len15_cyc", 32'(cyc), 32'd25);

    // clamped burst read with a dropped mem pulse mid-burst
    do_read(18'h200, 4'd9, 1'b1);
    check("len9_rd_n", 32'(rq.size()), 32'd8);
    check("len9_rd_cyc", 32'(cyc), 32'd17);
    for (int i = 0; i < 8; i++)
      check($sformatf("len9_rd%0d", i), 32'(i < rq.size() ? rq[i] : 16'h0), 32'h5000 + 32'(i));
    busy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (!u.ready || !ce_n) busy++;
    end
    check("dropped_mem_idle", 32'(busy), 32'd0);

    // read followed immediately by a write
    do_read(18'h100, 4'd1, 1'b0);
    check("turn_rd_data", 32'(rq.size() > 0 ? rq[0] : 16'h0), 32'hC0DE);
    wbuf[0] = 16'h1234;
    do_write(18'h101, 2'b11, 4'd1);
    check("turn_wr_acks", 32'(acks), 32'd1);
    do_read(18'h101, 4'd1, 1'b0);
    check("turn_rd_back", 32'(rq.size() > 0 ? rq[0] : 16'h0), 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_ctrl_burst.md
# sram_ctrl_burst

Parametrised asynchronous-SRAM controller, successor to the single-word 16-bit SRAM controller. Sits between a user-side request port (mem/rw/addr/data) and one external SRAM chip. Adds configurable address/data width, per-byte write enables, programmable access wait states, and multi-word incrementing bursts with per-word handshakes. Read data is presented both registered and raw.

## Interface
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width; multiple of 8; NB = DATA_W/8 byte lanes
- WAIT_CYC, 1, extra cycles per access beyond the minimum (0..15)
- BURST_MAX, 8, max words per request; LEN_W = clog2(BURST_MAX)+1

- clk  in  1  system clock, all flops rising-edge
- reset  in  1  asynchronous, active-high
- mem  in  1  request strobe, sampled only in IDLE
- rw  in  1  1 = read, 0 = write
- addr  in  ADDR_W  start word address
- be  in  NB  byte enables, held for the whole request
- burst_len  in  LEN_W  words to transfer
- data_f2s  in  DATA_W  write data; current word, advanced by source on wr_ack
- wr_ack  out  1  write word taken this cycle
- ready  out  1  controller idle, can accept mem
- data_s2f_r  out  DATA_W  registered read data
- rd_valid  out  1  data_s2f_r holds a new word this cycle
- data_s2f_ur  out  DATA_W  unregistered dio sample
- ad  out  ADDR_W  SRAM address
- we_n, oe_n, ce_n  out  1  SRAM strobes, active-low
- be_n  out  NB  SRAM byte-lane enables, active-low (ub/lb for NB=2)
- dio  inout  DATA_W  SRAM data bus

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE. ready = (state==IDLE).
- IDLE: ce_n=oe_n=we_n=1, be_n all 1, dio Z. On mem=1: latch addr, be, rw; latch len = burst_len with 0 -> 1 and >BURST_MAX -> BURST_MAX; go RD (rw=1) or WR_SETUP (rw=0). mem outside IDLE ignored.
- Write, first word: wr_ack=1 combinationally in the accept cycle (IDLE, mem=1, rw=0); data_f2s sampled on that edge into the write register.
- RD: ce_n=0, oe_n=0, we_n=1, be_n=~be_reg, ad=addr_reg. Wait counter runs WAIT_CYC+1 cycles; on the last cycle's edge dio is captured into data_s2f_r, and rd_valid=1 for the next cycle only. If words remain: addr_reg+1, stay RD (counter restarts); else IDLE.
- WR_SETUP (1 cycle): ce_n=0, oe_n=1, we_n=1, be_n=~be_reg, dio driven from the write register.
- WR_PULSE (WAIT_CYC+1 cycles): as WR_SETUP but we_n=0. In its last cycle, if words remain: wr_ack=1, next data_f2s sampled, addr_reg+1, go WR_SETUP; else go IDLE, wr_ack=0.
- Address increments modulo 2^ADDR_W (all-ones wraps to 0).
- dio is driven only in WR_SETUP/WR_PULSE; read-to-write always passes through IDLE, giving a one-cycle bus turnaround.
- data_s2f_ur = dio at all times; data_s2f_r holds its value until the next capture.
- Strobes, ad, be_n: Moore outputs of registered state; no input-to-strobe combinational path.

## Timing
- Reset (async, immediate): state IDLE, ready=1, ce_n=oe_n=we_n=1, be_n all 1, dio Z, ad=0, data_s2f_r=0, rd_valid=0, wr_ack=0, counters 0. Reset mid-burst aborts; we_n deasserts immediately; no further rd_valid/wr_ack.
- Read: mem accepted at edge 0; rd_valid for word k is high in cycle (k+1)(WAIT_CYC+1)+1. Burst of N returns to IDLE in the cycle rd_valid for word N-1 is high.
- Write: each word takes WAIT_CYC+2 cycles; N-word burst occupies N(WAIT_CYC+2) cycles after accept.
- Back-to-back: mem held high in the first IDLE cycle after completion is accepted; minimum one IDLE cycle between requests.
- WAIT_CYC=0: RD one cycle/word, WR_PULSE one cycle.

## Test plan
- Reset: assert reset mid-WR_PULSE -> same-cycle we_n=1, ce_n=1, dio Z, ready=1; after release, no wr_ack/rd_valid until new mem.
- Single write/read (WAIT_CYC=1): write 0x00F0 to addr 0xF0, be=2'b11; read back -> rd_valid in cycle 3 after accept, data_s2f_r=0x00F0.
- Byte lanes: write 0xAB12 be=2'b01 over 0xFFFF -> read gives 0xFF12; be_n=2'b10 during write.
- Burst: write 4 words 0x1111..0x4444 from addr 0x3FFFE -> 4 wr_ack pulses, ad sequence 0x3FFFE,0x3FFFF,0x00000,0x00001; 4-word read returns same data with rd_valid every 2 cycles.
- Length clamp: burst_len=0 -> exactly one word; burst_len=15 with BURST_MAX=8 -> exactly 8 words.
- Turnaround/ignored mem: read then immediate write -> at least one IDLE cycle with dio Z and oe_n=1 before WR_SETUP; mem pulses during busy are dropped (no extra accesses).
